// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array feeder and array top:
// default geometry, the packed row type and the feeder state encoding.
package sa_pkg;

    localparam int SA_WIDTH = 16;
    localparam int SA_SIZE  = 2;

    // One matrix row: element j lives in slice j.
    typedef logic [SA_SIZE-1:0][SA_WIDTH-1:0] row_t;

    typedef enum logic [1:0] {
        S_LOAD_B   = 2'd0,
        S_PUSH_B   = 2'd1,
        S_STREAM_A = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/sa_row_buf.sv
// SIZE-deep row buffer holding the B matrix between loading and pushing.
// One synchronous write port, one combinational read port. Contents are
// not reset; the feeder never reads a slot before rewriting it.
module sa_row_buf
    import sa_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH,
    parameter int SIZE  = SA_SIZE
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [$clog2(SIZE)-1:0]       wr_idx,
    input  logic [SIZE-1:0][WIDTH-1:0]    wr_row,
    input  logic [$clog2(SIZE)-1:0]       rd_idx,
    output logic [SIZE-1:0][WIDTH-1:0]    rd_row
);

    logic [SIZE-1:0][WIDTH-1:0] mem [SIZE];

    // Write the incoming row into its slot when the feeder strobes we.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_row;
        end
    end

    // Asynchronous read so the feeder can register the selected row directly.
    always_comb begin
        rd_row = mem[rd_idx];
    end

endmodule

// File: rtl/sa_feeder.sv
// Feeder for the systolic array: collects SIZE B rows, pushes them into the
// array as weights in reverse row order, then streams A rows as compute rows.
// Every output, including s_rdy and o_busy, comes straight from a flop.
module sa_feeder
    import sa_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH,
    parameter int SIZE  = SA_SIZE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_vld,
    output logic                          s_rdy,
    input  logic [SIZE-1:0][WIDTH-1:0]    s_row,
    input  logic                          s_last,
    input  logic                          i_keep_b,
    output logic                          o_we,
    output logic                          o_a_vld,
    output logic                          o_c_vld,
    output logic [SIZE-1:0][WIDTH-1:0]    o_a_rows,
    output logic                          o_busy
);

    localparam int IW = $clog2(SIZE);
    localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

    typedef logic [SIZE-1:0][WIDTH-1:0] frow_t;

    feeder_state_t state, state_nxt;
    logic [IW-1:0] b_idx, b_idx_nxt;
    logic [IW-1:0] p_idx, p_idx_nxt;
    logic          accept;
    logic          buf_we;
    frow_t         buf_rd_row;

    logic          we_nxt;
    logic          a_vld_nxt;
    logic          c_vld_nxt;
    logic          rdy_nxt;
    logic          busy_nxt;
    frow_t         rows_nxt;

    assign accept = s_vld & s_rdy;
    assign buf_we = accept && (state == S_LOAD_B);

    sa_row_buf #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE)
    ) u_row_buf (
        .clk    (clk),
        .we     (buf_we),
        .wr_idx (b_idx),
        .wr_row (s_row),
        .rd_idx (p_idx),
        .rd_row (buf_rd_row)
    );

    // State and index registers; reset abandons any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_LOAD_B;
            b_idx <= '0;
            p_idx <= '0;
        end else begin
            state <= state_nxt;
            b_idx <= b_idx_nxt;
            p_idx <= p_idx_nxt;
        end
    end

    // Next-state logic: count B beats, walk the buffer backwards, stream A.
    always_comb begin
        state_nxt = state;
        b_idx_nxt = b_idx;
        p_idx_nxt = p_idx;
        case (state)
            S_LOAD_B: begin
                if (accept) begin
                    if (b_idx == LAST_IDX) begin
                        state_nxt = S_PUSH_B;
                        b_idx_nxt = '0;
                        p_idx_nxt = LAST_IDX;
                    end else begin
                        b_idx_nxt = b_idx + IW'(1);
                    end
                end
            end
            S_PUSH_B: begin
                if (p_idx == '0) begin
                    state_nxt = S_STREAM_A;
                end else begin
                    p_idx_nxt = p_idx - IW'(1);
                end
            end
            S_STREAM_A: begin
                if (accept && s_last && !i_keep_b) begin
                    state_nxt = S_LOAD_B;
                    b_idx_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_LOAD_B;
                b_idx_nxt = '0;
                p_idx_nxt = '0;
            end
        endcase
    end

    // Output decode: next values of every registered output.
    always_comb begin
        we_nxt    = 1'b0;
        a_vld_nxt = 1'b0;
        c_vld_nxt = 1'b0;
        rows_nxt  = '0;
        case (state)
            S_PUSH_B: begin
                we_nxt    = 1'b1;
                a_vld_nxt = 1'b1;
                rows_nxt  = buf_rd_row;
            end
            S_STREAM_A: begin
                if (accept) begin
                    a_vld_nxt = 1'b1;
                    c_vld_nxt = 1'b1;
                    rows_nxt  = s_row;
                end
            end
            default: begin
                rows_nxt = '0;
            end
        endcase
        rdy_nxt  = (state_nxt != S_PUSH_B);
        busy_nxt = (state_nxt != S_LOAD_B) || (b_idx_nxt != '0);
    end

    // Output registers; all strobes and data are zero while reset is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_rdy    <= 1'b0;
            o_we     <= 1'b0;
            o_a_vld  <= 1'b0;
            o_c_vld  <= 1'b0;
            o_a_rows <= '0;
            o_busy   <= 1'b0;
        end else begin
            s_rdy    <= rdy_nxt;
            o_we     <= we_nxt;
            o_a_vld  <= a_vld_nxt;
            o_c_vld  <= c_vld_nxt;
            o_a_rows <= rows_nxt;
            o_busy   <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_sa_feeder.sv
// Testbench for sa_feeder (WIDTH=16, SIZE=2). A transaction-level model
// turns every accepted beat into the output rows expected on given cycles;
// each scenario task compares the captured output timeline against it.
module tb_sa_feeder;
    import sa_pkg::*;

    localparam int W = SA_WIDTH;
    localparam int N = SA_SIZE;

    typedef struct packed {
        logic we;
        logic av;
        logic cv;
        row_t rows;
    } out_t;

    logic clk = 1'b0;
    logic rst;
    logic s_vld;
    logic s_rdy;
    row_t s_row;
    logic s_last;
    logic i_keep_b;
    logic o_we;
    logic o_a_vld;
    logic o_c_vld;
    row_t o_a_rows;
    logic o_busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit capture = 0;
    int last_acc_cyc = 0;

    out_t cap_q[$];
    int   cap_cyc[$];
    logic cap_rdy[$];
    out_t exp_map[int];

    bit   m_loading;
    int   m_cnt;
    row_t m_b[N];

    sa_feeder #(.WIDTH(W), .SIZE(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_vld    (s_vld),
        .s_rdy    (s_rdy),
        .s_row    (s_row),
        .s_last   (s_last),
        .i_keep_b (i_keep_b),
        .o_we     (o_we),
        .o_a_vld  (o_a_vld),
        .o_c_vld  (o_c_vld),
        .o_a_rows (o_a_rows),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the outputs produced by each rising edge, tagged with its index.
    always begin
        @(posedge clk);
        #1;
        if (capture) begin
            cap_q.push_back({o_we, o_a_vld, o_c_vld, o_a_rows});
            cap_cyc.push_back(cyc);
            cap_rdy.push_back(s_rdy);
        end
    end

    function automatic row_t mk(input int a, input int b);
        row_t r;
        r[0] = W'(a);
        r[1] = W'(b);
        return r;
    endfunction

    function automatic row_t rand_row();
        return row_t'($urandom);
    endfunction

    function automatic void model_reset();
        m_loading = 1'b1;
        m_cnt = 0;
        exp_map.delete();
    endfunction

    // Beat accepted at edge c: B rows come out newest-first on the SIZE edges
    // after the last B beat; an A row comes out on its own acceptance edge.
    function automatic void model_accept(input int c, input row_t row,
                                         input logic last, input logic keep);
        out_t o;
        if (m_loading) begin
            m_b[m_cnt] = row;
            m_cnt++;
            if (m_cnt == N) begin
                for (int j = 0; j < N; j++) begin
                    o.we = 1'b1; o.av = 1'b1; o.cv = 1'b0; o.rows = m_b[j];
                    exp_map[c + N - j] = o;
                end
                m_loading = 1'b0;
            end
        end else begin
            o.we = 1'b0; o.av = 1'b1; o.cv = 1'b1; o.rows = row;
            exp_map[c] = o;
            if (last && !keep) begin
                m_loading = 1'b1;
                m_cnt = 0;
            end
        end
    endfunction

    task automatic idle(input int n);
        s_vld = 1'b0;
        s_row = rand_row();
        s_last = 1'($urandom_range(0, 1));
        repeat (n) @(negedge clk);
    endtask

    // Present one beat from a falling edge and hold it until accepted.
    task automatic send_beat(input row_t row, input logic last, input logic keep);
        int waitc = 0;
        s_vld = 1'b1;
        s_row = row;
        s_last = last;
        i_keep_b = keep;
        while (s_rdy !== 1'b1) begin
            @(negedge clk);
            waitc++;
            if (waitc > 50) begin
                vectors++;
                miscompares++;
                $display("FAIL handshake_timeout: s_rdy=%b after %0d cycles, required 1", s_rdy, waitc);
                s_vld = 1'b0;
                return;
            end
        end
        @(posedge clk);
        @(negedge clk);
        last_acc_cyc = cyc;
        model_accept(cyc, row, last, keep);
        s_vld = 1'b0;
    endtask

    task automatic start_capture();
        cap_q.delete();
        cap_cyc.delete();
        cap_rdy.delete();
        capture = 1'b1;
    endtask

    task automatic stop_capture();
        idle(N + 3);
        capture = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_vld = 1'b0; s_row = '0; s_last = 1'b0; i_keep_b = 1'b0;
        model_reset();
        #3;
        vectors++;
        if ({s_rdy, o_we, o_a_vld, o_c_vld, o_busy, o_a_rows} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: rdy/we/av/cv/busy=%b%b%b%b%b rows=%h, required all 0",
                     s_rdy, o_we, o_a_vld, o_c_vld, o_busy, o_a_rows);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({s_rdy, o_busy, o_a_vld} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_release: rdy/busy/av=%b%b%b, required 100", s_rdy, o_busy, o_a_vld);
        end
    endtask

    task automatic test_continuous();
        int kb;
        int navail = 0;
        start_capture();
        send_beat(mk(1, 2), 1'b0, 1'b0);
        vectors++;
        if (o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_after_b0: got %b, required 1", o_busy);
        end
        send_beat(mk(3, 4), 1'b0, 1'b0);
        kb = last_acc_cyc;
        send_beat(mk(1, 2), 1'b0, 1'b0);
        vectors++;
        if (last_acc_cyc !== kb + N + 1) begin
            miscompares++;
            $display("FAIL first_a_latency: accepted at edge %0d, required %0d", last_acc_cyc, kb + N + 1);
        end
        send_beat(mk(3, 4), 1'b1, 1'b0);
        vectors++;
        if (o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_after_last: got %b, required 0", o_busy);
        end
        stop_capture();
        foreach (cap_q[i]) begin
            out_t e;
            e = exp_map.exists(cap_cyc[i]) ? exp_map[cap_cyc[i]] : '0;
            if (cap_q[i].av) navail++;
            vectors++;
            if (cap_q[i] !== e) begin
                miscompares++;
                $display("FAIL continuous edge %0d: got we/av/cv=%b%b%b rows=%h, required %b%b%b rows=%h",
                         cap_cyc[i], cap_q[i].we, cap_q[i].av, cap_q[i].cv, cap_q[i].rows, e.we, e.av, e.cv, e.rows);
            end
        end
        vectors++;
        if (navail !== 4) begin
            miscompares++;
            $display("FAIL continuous_count: got %0d valid rows, required 4", navail);
        end
    endtask

    task automatic test_gap_b();
        int nlow = 0;
        start_capture();
        send_beat(mk(1, 2), 1'b0, 1'b0);
        idle(1);
        send_beat(mk(3, 4), 1'b0, 1'b0);
        send_beat(mk(1, 2), 1'b0, 1'b0);
        send_beat(mk(3, 4), 1'b1, 1'b0);
        stop_capture();
        foreach (cap_q[i]) begin
            out_t e;
            e = exp_map.exists(cap_cyc[i]) ? exp_map[cap_cyc[i]] : '0;
            if (cap_rdy[i] === 1'b0) nlow++;
            vectors++;
            if (cap_q[i] !== e) begin
                miscompares++;
                $display("FAIL gap_b edge %0d: got we/av/cv=%b%b%b rows=%h, required %b%b%b rows=%h",
                         cap_cyc[i], cap_q[i].we, cap_q[i].av, cap_q[i].cv, cap_q[i].rows, e.we, e.av, e.cv, e.rows);
            end
        end
        vectors++;
        if (nlow !== N) begin
            miscompares++;
            $display("FAIL gap_b_rdy_low: s_rdy low %0d cycles, required %0d", nlow, N);
        end
    endtask

    task automatic test_gap_a();
        start_capture();
        send_beat(mk(1, 2), 1'b0, 1'b0);
        send_beat(mk(3, 4), 1'b0, 1'b0);
        send_beat(mk(1, 2), 1'b0, 1'b0);
        idle(1);
        send_beat(mk(3, 4), 1'b1, 1'b0);
        stop_capture();
        foreach (cap_q[i]) begin
            out_t e;
            e = exp_map.exists(cap_cyc[i]) ? exp_map[cap_cyc[i]] : '0;
            vectors++;
            if (cap_q[i] !== e) begin
                miscompares++;
                $display("FAIL gap_a edge %0d: got we/av/cv=%b%b%b rows=%h, required %b%b%b rows=%h",
                         cap_cyc[i], cap_q[i].we, cap_q[i].av, cap_q[i].cv, cap_q[i].rows, e.we, e.av, e.cv, e.rows);
            end
        end
    endtask

    task automatic test_keep_b();
        int nwe = 0;
        int nav = 0;
        send_beat(mk(1, 2), 1'b0, 1'b0);
        send_beat(mk(3, 4), 1'b0, 1'b0);
        send_beat(mk(1, 2), 1'b0, 1'b0);
        send_beat(mk(3, 4), 1'b1, 1'b1);
        start_capture();
        send_beat(mk(5, 6), 1'b0, 1'b0);
        send_beat(mk(7, 8), 1'b1, 1'b0);
        stop_capture();
        foreach (cap_q[i]) begin
            out_t e;
            e = exp_map.exists(cap_cyc[i]) ? exp_map[cap_cyc[i]] : '0;
            if (cap_q[i].we) nwe++;
            if (cap_q[i].av) nav++;
            vectors++;
            if (cap_q[i] !== e) begin
                miscompares++;
                $display("FAIL keep_b edge %0d: got we/av/cv=%b%b%b rows=%h, required %b%b%b rows=%h",
                         cap_cyc[i], cap_q[i].we, cap_q[i].av, cap_q[i].cv, cap_q[i].rows, e.we, e.av, e.cv, e.rows);
            end
        end
        vectors++;
        if (nwe !== 0 || nav !== 2) begin
            miscompares++;
            $display("FAIL keep_b_counts: got %0d we / %0d valid, required 0 / 2", nwe, nav);
        end
    endtask

    task automatic test_reset_mid_push();
        send_beat(mk(1, 2), 1'b0, 1'b0);
        send_beat(mk(3, 4), 1'b0, 1'b0);
        @(posedge clk);
        #2;
        vectors++;
        if (o_we !== 1'b1 || o_a_rows !== mk(3, 4)) begin
            miscompares++;
            $display("FAIL push_before_reset: we=%b rows=%h, required 1 rows=%h", o_we, o_a_rows, mk(3, 4));
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({s_rdy, o_we, o_a_vld, o_c_vld, o_busy, o_a_rows} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: rdy/we/av/cv/busy=%b%b%b%b%b rows=%h, required all 0",
                     s_rdy, o_we, o_a_vld, o_c_vld, o_busy, o_a_rows);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        start_capture();
        send_beat(mk(5, 6), 1'b0, 1'b0);
        send_beat(mk(7, 8), 1'b0, 1'b0);
        send_beat(mk(1, 2), 1'b0, 1'b0);
        send_beat(mk(3, 4), 1'b1, 1'b0);
        stop_capture();
        foreach (cap_q[i]) begin
            out_t e;
            e = exp_map.exists(cap_cyc[i]) ? exp_map[cap_cyc[i]] : '0;
            vectors++;
            if (cap_q[i] !== e) begin
                miscompares++;
                $display("FAIL after_reset edge %0d: got we/av/cv=%b%b%b rows=%h, required %b%b%b rows=%h",
                         cap_cyc[i], cap_q[i].we, cap_q[i].av, cap_q[i].cv, cap_q[i].rows, e.we, e.av, e.cv, e.rows);
            end
        end
    endtask

    task automatic test_negative();
        start_capture();
        send_beat(mk(-1, 2), 1'b0, 1'b0);
        send_beat(mk(3, -4), 1'b0, 1'b0);
        send_beat(mk(-1, 2), 1'b0, 1'b0);
        send_beat(mk(3, -4), 1'b1, 1'b0);
        stop_capture();
        foreach (cap_q[i]) begin
            out_t e;
            e = exp_map.exists(cap_cyc[i]) ? exp_map[cap_cyc[i]] : '0;
            vectors++;
            if (cap_q[i] !== e) begin
                miscompares++;
                $display("FAIL negative edge %0d: got we/av/cv=%b%b%b rows=%h, required %b%b%b rows=%h",
                         cap_cyc[i], cap_q[i].we, cap_q[i].av, cap_q[i].cv, cap_q[i].rows, e.we, e.av, e.cv, e.rows);
            end
        end
    endtask

    task automatic test_random();
        int n;
        start_capture();
        for (int j = 0; j < 20; j++) begin
            if (m_loading) begin
                for (int r = 0; r < N; r++) begin
                    idle($urandom_range(0, 2));
                    send_beat(rand_row(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
            end
            n = $urandom_range(1, 4);
            for (int a = 0; a < n; a++) begin
                idle($urandom_range(0, 2));
                send_beat(rand_row(), a == n - 1, 1'($urandom_range(0, 1)));
            end
        end
        stop_capture();
        foreach (cap_q[i]) begin
            out_t e;
            e = exp_map.exists(cap_cyc[i]) ? exp_map[cap_cyc[i]] : '0;
            vectors++;
            if (cap_q[i] !== e) begin
                miscompares++;
                $display("FAIL random edge %0d: got we/av/cv=%b%b%b rows=%h, required %b%b%b rows=%h",
                         cap_cyc[i], cap_q[i].we, cap_q[i].av, cap_q[i].cv, cap_q[i].rows, e.we, e.av, e.cv, e.rows);
            end
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gap_b();
        test_gap_a();
        test_keep_b();
        test_reset_mid_push();
        test_negative();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/sa_feeder.md
SA_FEEDER -- requirements
Module: sa_feeder

Interface
REQ-001 Parameter WIDTH, default 16, element width in bits (signed two's complement).
REQ-002 Parameter SIZE, default 2, systolic array dimension; legal range 2..16.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 s_vld  input  1  upstream row valid.
REQ-006 s_rdy  output  1  feeder accepts s_row this cycle; a beat is accepted when s_vld and s_rdy are both high at a rising edge.
REQ-007 s_row  input  SIZE x WIDTH  upstream matrix row; element j in slice j.
REQ-008 s_last  input  1  marks final A row of a batch; ignored on B beats.
REQ-009 i_keep_b  input  1  sampled with the s_last beat; high keeps the loaded B for the next batch.
REQ-010 o_we  output  1  to sa_top i_we; weight-load strobe.
REQ-011 o_a_vld  output  1  to sa_top i_a_vld.
REQ-012 o_c_vld  output  1  to sa_top i_c_vld; marks a compute row.
REQ-013 o_a_rows  output  SIZE x WIDTH  to sa_top i_a_rows.
REQ-014 o_busy  output  1  high in any state other than S_LOAD_B with zero B beats taken.

Function
REQ-015 The FSM SHALL have states S_LOAD_B, S_PUSH_B, S_STREAM_A.
REQ-016 S_LOAD_B: s_rdy=1; each accepted beat is written to buffer slot b_idx and b_idx increments; the SIZE-th accepted beat SHALL move the FSM to S_PUSH_B with p_idx=SIZE-1.
REQ-017 S_PUSH_B: s_rdy=0; exactly SIZE cycles; each cycle registers buffer[p_idx] onto o_a_rows with o_we=1, o_a_vld=1, o_c_vld=0, then decrements p_idx (B issued in reverse row order).
REQ-018 After the cycle issuing slot 0 the FSM SHALL enter S_STREAM_A, so B row 0 and the first A row may appear on back-to-back cycles with no bubble.
REQ-019 S_STREAM_A: s_rdy=1; an accepted beat SHALL appear on o_a_rows one cycle later with o_a_vld=1, o_c_vld=1, o_we=0.
REQ-020 S_STREAM_A with s_vld low SHALL produce an idle output cycle: o_a_vld=0, o_c_vld=0, o_we=0; idle cycles may occur between any two A rows.
REQ-021 Accepted s_last with i_keep_b=0 SHALL return to S_LOAD_B with b_idx=0; with i_keep_b=1 the FSM SHALL stay in S_STREAM_A and the buffer SHALL be retained.
REQ-022 Gaps in S_LOAD_B (s_vld low) SHALL not advance b_idx and SHALL drive all output strobes low.
REQ-023 o_a_rows SHALL be all zeros whenever o_a_vld=0.
REQ-024 o_we and o_c_vld SHALL never be high in the same cycle.
REQ-025 Data is passed bit-exact; no arithmetic, saturation or sign extension is performed.

Reset
REQ-026 rst high SHALL immediately force: state S_LOAD_B, b_idx=0, p_idx=0, s_rdy=0 while rst asserted, o_we=0, o_a_vld=0, o_c_vld=0, o_a_rows=0, o_busy=0.
REQ-027 Buffer contents need not be reset; they SHALL never be emitted before being rewritten after reset.
REQ-028 Reset mid-S_PUSH_B or mid-S_STREAM_A SHALL abandon the job; the next accepted beat after reset is treated as B row 0.

Structure
REQ-029 Package sa_pkg SHALL hold WIDTH/SIZE defaults, the row type (SIZE x WIDTH packed array) and the feeder state enum; sa_top shares the row type.
REQ-030 One sub-module sa_row_buf SHALL implement the SIZE-deep row buffer (one write port, one read port, index widths $clog2(SIZE)).
REQ-031 All sa_feeder outputs SHALL be registered.

Verification (WIDTH=16, SIZE=2, sa_feeder driving sa_top, C model checks results)
REQ-032 B rows [1,2],[3,4] then A rows [1,2],[3,4] continuous -> o_a_rows sequence [3,4](we),[1,2](we),[1,2](c_vld),[3,4](c_vld) on 4 consecutive cycles; sa_top output C=[[7,10],[15,22]].
REQ-033 One idle cycle between B beats -> push sequence unchanged, s_rdy low for exactly 2 cycles during S_PUSH_B, same C.
REQ-034 One idle cycle between A rows -> one cycle with o_a_vld=o_c_vld=0 between compute rows; C unchanged.
REQ-035 s_last with i_keep_b=1, then A rows [5,6],[7,8] -> no o_we cycles, second C=[[23,34],[31,46]].
REQ-036 rst asserted for 1 cycle during S_PUSH_B after [3,4] issued -> all outputs 0 asynchronously, next beats loaded as fresh B, full job correct.
REQ-037 Negative values B=[[-1,2],[3,-4]], A=[[-1,2],[3,-4]] -> bit-exact pass-through, C=[[7,-10],[-15,22]].
